control_sequencer: RTL and testbench

- Hardwired Moore control unit that sequences the single-bus CPU datapath.
- Generates every datapath strobe per T-state, replacing bench-driven control.
- Runs the fetch cycle T0–T2, then per-opcode execute states T3–T6, then returns to T0.
- Decodes IR[31:27]. Sits beside the CPU top; its outputs wire directly to the CPU control inputs.

---
 rtl/control_sequencer_if.sv | 24 ++
 rtl/control_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control-strobe bundle from the sequencer to the single-bus CPU datapath.
// The sequencer drives through master; the CPU top listens through slave.
interface control_sequencer_if;
    logic [11:0] drv;
    logic [10:0] ld;
    logic [2:0]  sel;
    logic        Rout;
    logic [12:0] alu;
    logic        Read;
    logic        IncPC;
    logic        run;
    logic        illegal;
    logic [3:0]  state_dbg;

    modport master (
        output drv, ld, sel, Rout, alu, Read, IncPC,
        output run, illegal, state_dbg
    );

    modport slave (
        input drv, ld, sel, Rout, alu, Read, IncPC,
        input run, illegal, state_dbg
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, per-opcode execute T3-T6.
// Optional single-step mode is enabled by defining CONTROL_SINGLE_STEP_EN.
module control_sequencer #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned OPC_W    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         IR,
`ifdef CONTROL_SINGLE_STEP_EN
    input  logic                step,
`endif
    control_sequencer_if.master ctl
);

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        T0        = 4'd1,
        T1        = 4'd2,
        T2        = 4'd3,
        T3        = 4'd4,
        T4        = 4'd5,
        T5        = 4'd6,
        T6        = 4'd7,
        HALT      = 4'd8,
        STEP_WAIT = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        C_RR, C_IMM, C_LDI, C_MD, C_UN,
        C_MFLO, C_MFHI, C_IN, C_OUT, C_NOP, C_HALT
    } cls_e;

    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'b00001);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
    localparam logic [OPC_W-1:0] OP_ROR  = OPC_W'(5'b00111);
    localparam logic [OPC_W-1:0] OP_ROL  = OPC_W'(5'b01000);
    localparam logic [OPC_W-1:0] OP_SHR  = OPC_W'(5'b01001);
    localparam logic [OPC_W-1:0] OP_SHRA = OPC_W'(5'b01010);
    localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(5'b01011);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'b01100);
    localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(5'b01101);
    localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(5'b01110);
    localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(5'b01111);
    localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(5'b10000);
    localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(5'b10001);
    localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(5'b10010);
    localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(5'b10110);
    localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(5'b10111);
    localparam logic [OPC_W-1:0] OP_MFLO = OPC_W'(5'b11000);
    localparam logic [OPC_W-1:0] OP_MFHI = OPC_W'(5'b11001);
    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(5'b11010);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11011);

    localparam logic [12:0] A_AND  = 13'b1 << 12;
    localparam logic [12:0] A_OR   = 13'b1 << 11;
    localparam logic [12:0] A_ADD  = 13'b1 << 10;
    localparam logic [12:0] A_SUB  = 13'b1 << 9;
    localparam logic [12:0] A_MUL  = 13'b1 << 8;
    localparam logic [12:0] A_DIV  = 13'b1 << 7;
    localparam logic [12:0] A_SHR  = 13'b1 << 6;
    localparam logic [12:0] A_SHRA = 13'b1 << 5;
    localparam logic [12:0] A_SHL  = 13'b1 << 4;
    localparam logic [12:0] A_ROR  = 13'b1 << 3;
    localparam logic [12:0] A_ROL  = 13'b1 << 2;
    localparam logic [12:0] A_NEG  = 13'b1 << 1;
    localparam logic [12:0] A_NOT  = 13'b1;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

`ifdef CONTROL_SINGLE_STEP_EN
    localparam state_e DONE_S = STEP_WAIT;
`else
    localparam state_e DONE_S = T0;
`endif

    state_e           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [OPC_W-1:0] opc;
    cls_e             cls;
    logic [12:0]      aluop;
    logic             bad;
    logic             unused_ir;

    logic [11:0] drv;
    logic [10:0] ld;
    logic [2:0]  sel;
    logic        rout, rd, inc, run, ill;
    logic [12:0] alu;
    logic        step_go;

    assign opc       = IR[31 -: OPC_W];
    assign unused_ir = ^IR[31-OPC_W:0];

`ifdef CONTROL_SINGLE_STEP_EN
    logic [2:0] step_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) step_q <= '0;
        else        step_q <= {step_q[1:0], step};
    end

    assign step_go = step_q[1] & ~step_q[2];
`else
    assign step_go = 1'b0;
`endif

    always_comb begin
        cls   = C_NOP;
        aluop = '0;
        bad   = 1'b0;
        case (opc)
            OP_ADD:  begin cls = C_RR;  aluop = A_ADD;  end
            OP_SUB:  begin cls = C_RR;  aluop = A_SUB;  end
            OP_AND:  begin cls = C_RR;  aluop = A_AND;  end
            OP_OR:   begin cls = C_RR;  aluop = A_OR;   end
            OP_ROR:  begin cls = C_RR;  aluop = A_ROR;  end
            OP_ROL:  begin cls = C_RR;  aluop = A_ROL;  end
            OP_SHR:  begin cls = C_RR;  aluop = A_SHR;  end
            OP_SHRA: begin cls = C_RR;  aluop = A_SHRA; end
            OP_SHL:  begin cls = C_RR;  aluop = A_SHL;  end
            OP_ADDI: begin cls = C_IMM; aluop = A_ADD;  end
            OP_ANDI: begin cls = C_IMM; aluop = A_AND;  end
            OP_ORI:  begin cls = C_IMM; aluop = A_OR;   end
            OP_LDI:  begin cls = C_LDI; aluop = A_ADD;  end
            OP_MUL:  begin cls = C_MD;  aluop = A_MUL;  end
            OP_DIV:  begin cls = C_MD;  aluop = A_DIV;  end
            OP_NEG:  begin cls = C_UN;  aluop = A_NEG;  end
            OP_NOT:  begin cls = C_UN;  aluop = A_NOT;  end
            OP_MFLO: cls = C_MFLO;
            OP_MFHI: cls = C_MFHI;
            OP_IN:   cls = C_IN;
            OP_OUT:  cls = C_OUT;
            OP_NOP:  cls = C_NOP;
            OP_HALT: cls = C_HALT;
            default: bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        drv     = '0;
        ld      = '0;
        sel     = '0;
        rout    = 1'b0;
        alu     = '0;
        rd      = 1'b0;
        inc     = 1'b0;
        run     = 1'b0;
        ill     = 1'b0;
        case (state_q)
            S_RST: state_d = DONE_S;
            T0: begin
                run     = 1'b1;
                inc     = 1'b1;
                ld[4]   = 1'b1;
                ld[8]   = 1'b1;
                wait_d  = '0;
                state_d = T1;
            end
            T1: begin
                run   = 1'b1;
                rd    = 1'b1;
                ld[3] = 1'b1;
                if (wait_q == WAIT_LAST) state_d = T2;
                else                     wait_d  = wait_q + 4'd1;
            end
            T2: begin
                run    = 1'b1;
                drv[5] = 1'b1;
                ld[7]  = 1'b1;
                ill    = bad;
                if (cls == C_HALT)     state_d = HALT;
                else if (cls == C_NOP) state_d = DONE_S;
                else                   state_d = T3;
            end
            T3: begin
                run     = 1'b1;
                state_d = T4;
                case (cls)
                    C_RR, C_IMM: begin sel[1] = 1'b1; rout = 1'b1; ld[5] = 1'b1; end
                    C_LDI:  begin sel[1] = 1'b1; drv[0] = 1'b1; ld[5] = 1'b1; end
                    C_MD:   begin sel[2] = 1'b1; rout = 1'b1; ld[5] = 1'b1; end
                    C_UN: begin
                        sel[1] = 1'b1;
                        rout   = 1'b1;
                        alu    = aluop;
                        ld[6]  = 1'b1;
                    end
                    C_MFLO: begin drv[10] = 1'b1; sel[2] = 1'b1; ld[0] = 1'b1; end
                    C_MFHI: begin drv[11] = 1'b1; sel[2] = 1'b1; ld[0] = 1'b1; end
                    C_IN:   begin drv[4]  = 1'b1; sel[2] = 1'b1; ld[0] = 1'b1; end
                    C_OUT:  begin sel[2]  = 1'b1; rout = 1'b1; ld[1] = 1'b1; end
                    default: ;
                endcase
                if (cls inside {C_MFLO, C_MFHI, C_IN, C_OUT}) state_d = DONE_S;
            end
            T4: begin
                run     = 1'b1;
                state_d = T5;
                case (cls)
                    C_RR: begin
                        sel[0] = 1'b1;
                        rout   = 1'b1;
                        alu    = aluop;
                        ld[6]  = 1'b1;
                    end
                    C_IMM, C_LDI: begin drv[3] = 1'b1; alu = aluop; ld[6] = 1'b1; end
                    C_MD: begin
                        sel[1] = 1'b1;
                        rout   = 1'b1;
                        alu    = aluop;
                        ld[6]  = 1'b1;
                    end
                    C_UN: begin
                        drv[8]  = 1'b1;
                        sel[2]  = 1'b1;
                        ld[0]   = 1'b1;
                        state_d = DONE_S;
                    end
                    default: ;
                endcase
            end
            T5: begin
                run     = 1'b1;
                state_d = T6;
                drv[8]  = 1'b1;
                if (cls == C_MD) ld[9] = 1'b1;
                else begin sel[2] = 1'b1; ld[0] = 1'b1; end
            end
            // ALU classes spend a quiet T6 so every long op retires from T6
            T6: begin
                run     = 1'b1;
                state_d = DONE_S;
                if (cls == C_MD) begin drv[9] = 1'b1; ld[10] = 1'b1; end
            end
            HALT: state_d = HALT;
`ifdef CONTROL_SINGLE_STEP_EN
            STEP_WAIT: begin
                run = 1'b1;
                if (step_go) state_d = T0;
            end
`endif
            default: state_d = S_RST;
        endcase
    end

    assign ctl.drv       = drv;
    assign ctl.ld        = ld;
    assign ctl.sel       = sel;
    assign ctl.Rout      = rout;
    assign ctl.alu       = alu;
    assign ctl.Read      = rd;
    assign ctl.IncPC     = inc;
    assign ctl.run       = run;
    assign ctl.illegal   = ill;
    assign ctl.state_dbg = state_q;

    logic unused_step;
    assign unused_step = step_go;

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer: per-cycle strobe vectors plus
// hand-written reset-abort and MEM_WAIT=3 sequences.
module tb_control_sequencer;

    localparam logic [11:0] D_HIOUT  = 12'h800;
    localparam logic [11:0] D_LOOUT  = 12'h400;
    localparam logic [11:0] D_ZHI    = 12'h200;
    localparam logic [11:0] D_ZLO    = 12'h100;
    localparam logic [11:0] D_MDROUT = 12'h020;
    localparam logic [11:0] D_INOUT  = 12'h010;
    localparam logic [11:0] D_COUT   = 12'h008;
    localparam logic [11:0] D_BAOUT  = 12'h001;

    localparam logic [10:0] L_HIIN  = 11'h400;
    localparam logic [10:0] L_LOIN  = 11'h200;
    localparam logic [10:0] L_PCIN  = 11'h100;
    localparam logic [10:0] L_IRIN  = 11'h080;
    localparam logic [10:0] L_ZIN   = 11'h040;
    localparam logic [10:0] L_YIN   = 11'h020;
    localparam logic [10:0] L_MARIN = 11'h010;
    localparam logic [10:0] L_MDRIN = 11'h008;
    localparam logic [10:0] L_OUTP  = 11'h002;
    localparam logic [10:0] L_RIN   = 11'h001;

    localparam logic [2:0] S_GRA = 3'b100;
    localparam logic [2:0] S_GRB = 3'b010;
    localparam logic [2:0] S_GRC = 3'b001;

    localparam logic [12:0] A_AND = 13'h1000;
    localparam logic [12:0] A_ADD = 13'h0400;
    localparam logic [12:0] A_SUB = 13'h0200;
    localparam logic [12:0] A_MUL = 13'h0100;
    localparam logic [12:0] A_DIV = 13'h0080;
    localparam logic [12:0] A_ROR = 13'h0008;
    localparam logic [12:0] A_NEG = 13'h0002;

    typedef struct {
        logic [31:0] ir;
        logic [43:0] exp;
        string       nm;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir1, ir3;
    logic [43:0] o1, o3;
    logic        hl_seen;
    int          nvec = 0;
    int          nerr = 0;
    vec_t        tq[$];

    control_sequencer_if c1();
    control_sequencer_if c3();

    always #5 clk = ~clk;

    control_sequencer #(.MEM_WAIT(1)) dut1 (
        .clk(clk),
        .reset(reset),
        .IR(ir1),
`ifdef CONTROL_SINGLE_STEP_EN
        .step(1'b0),
`endif
        .ctl(c1)
    );

    control_sequencer #(.MEM_WAIT(3)) dut3 (
        .clk(clk),
        .reset(reset),
        .IR(ir3),
`ifdef CONTROL_SINGLE_STEP_EN
        .step(1'b0),
`endif
        .ctl(c3)
    );

    assign o1 = {c1.drv, c1.ld, c1.sel, c1.Rout, c1.alu,
                 c1.Read, c1.IncPC, c1.run, c1.illegal};
    assign o3 = {c3.drv, c3.ld, c3.sel, c3.Rout, c3.alu,
                 c3.Read, c3.IncPC, c3.run, c3.illegal};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [43:0] pk(
        input logic [11:0] d, input logic [10:0] l, input logic [2:0] s,
        input logic r, input logic [12:0] a, input logic rd,
        input logic inc, input logic rn, input logic il);
        return {d, l, s, r, a, rd, inc, rn, il};
    endfunction

    function automatic void push(input string nm, input logic [31:0] ir,
                                 input logic [43:0] e);
        vec_t v;
        v.ir  = ir;
        v.exp = e;
        v.nm  = nm;
        tq.push_back(v);
    endfunction

    function automatic void ex(input string nm, input logic [31:0] ir,
                               input logic [11:0] d, input logic [10:0] l,
                               input logic [2:0] s, input logic r,
                               input logic [12:0] a);
        push(nm, ir, pk(d, l, s, r, a, 1'b0, 1'b0, 1'b1, 1'b0));
    endfunction

    function automatic void fetch(input string nm, input logic [31:0] ir,
                                  input logic il);
        push({nm, "_t0"}, ir,
             pk('0, L_PCIN | L_MARIN, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0));
        push({nm, "_t1"}, ir,
             pk('0, L_MDRIN, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0));
        push({nm, "_t2"}, ir,
             pk(D_MDROUT, L_IRIN, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, il));
    endfunction

    function automatic void rr(input string nm, input logic [31:0] ir,
                               input logic [12:0] a);
        fetch(nm, ir, 1'b0);
        ex({nm, "_t3"}, ir, '0, L_YIN, S_GRB, 1'b1, '0);
        ex({nm, "_t4"}, ir, '0, L_ZIN, S_GRC, 1'b1, a);
        ex({nm, "_t5"}, ir, D_ZLO, L_RIN, S_GRA, 1'b0, '0);
        ex({nm, "_t6"}, ir, '0, '0, '0, 1'b0, '0);
    endfunction

    always @(negedge clk) begin
        chk("bus_onehot",
            64'(($countones({c1.drv, c1.Rout}) <= 1) &&
                ($countones(c1.alu) <= 1)), 64'd1);
    end

    always @(c1.ld) begin
        if (c1.ld[10] | c1.ld[9]) hl_seen = 1'b1;
    end

    initial begin
        int rdc;
        logic rz;

        rr("add", 32'h1989_0000, A_ADD);
        fetch("mul", 32'h8000_0000, 1'b0);
        ex("mul_t3", 32'h8000_0000, '0, L_YIN, S_GRA, 1'b1, '0);
        ex("mul_t4", 32'h8000_0000, '0, L_ZIN, S_GRB, 1'b1, A_MUL);
        ex("mul_t5", 32'h8000_0000, D_ZLO, L_LOIN, '0, 1'b0, '0);
        ex("mul_t6", 32'h8000_0000, D_ZHI, L_HIIN, '0, 1'b0, '0);
        fetch("mflo", 32'hC000_0000, 1'b0);
        ex("mflo_t3", 32'hC000_0000, D_LOOUT, L_RIN, S_GRA, 1'b0, '0);
        rr("sub", 32'h2000_0000, A_SUB);
        fetch("andi", 32'h6800_0000, 1'b0);
        ex("andi_t3", 32'h6800_0000, '0, L_YIN, S_GRB, 1'b1, '0);
        ex("andi_t4", 32'h6800_0000, D_COUT, L_ZIN, '0, 1'b0, A_AND);
        ex("andi_t5", 32'h6800_0000, D_ZLO, L_RIN, S_GRA, 1'b0, '0);
        ex("andi_t6", 32'h6800_0000, '0, '0, '0, 1'b0, '0);
        fetch("neg", 32'h8800_0000, 1'b0);
        ex("neg_t3", 32'h8800_0000, '0, L_ZIN, S_GRB, 1'b1, A_NEG);
        ex("neg_t4", 32'h8800_0000, D_ZLO, L_RIN, S_GRA, 1'b0, '0);
        fetch("out", 32'hB800_0000, 1'b0);
        ex("out_t3", 32'hB800_0000, '0, L_OUTP, S_GRA, 1'b1, '0);
        fetch("ldi", 32'h0800_0000, 1'b0);
        ex("ldi_t3", 32'h0800_0000, D_BAOUT, L_YIN, S_GRB, 1'b0, '0);
        ex("ldi_t4", 32'h0800_0000, D_COUT, L_ZIN, '0, 1'b0, A_ADD);
        ex("ldi_t5", 32'h0800_0000, D_ZLO, L_RIN, S_GRA, 1'b0, '0);
        ex("ldi_t6", 32'h0800_0000, '0, '0, '0, 1'b0, '0);
        fetch("bad", 32'hF800_0000, 1'b1);
        fetch("in", 32'hB000_0000, 1'b0);
        ex("in_t3", 32'hB000_0000, D_INOUT, L_RIN, S_GRA, 1'b0, '0);
        fetch("mfhi", 32'hC800_0000, 1'b0);
        ex("mfhi_t3", 32'hC800_0000, D_HIOUT, L_RIN, S_GRA, 1'b0, '0);
        rr("ror", 32'h3800_0000, A_ROR);
        fetch("halt", 32'hD800_0000, 1'b0);
        for (int i = 0; i < 20; i++) push("halt_idle", 32'hD800_0000, '0);

        reset   = 1'b0;
        ir1     = 32'h1989_0000;
        ir3     = 32'hD000_0000;
        hl_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out1", o1, '0);
            chk("rst_out3", o3, '0);
        end
        reset = 1'b1;

        foreach (tq[i]) begin
            @(posedge clk);
            #1 ir1 = tq[i].ir;
            @(negedge clk);
            chk(tq[i].nm, o1, tq[i].exp);
        end

        @(negedge clk);
        reset   = 1'b0;
        ir1     = 32'h7800_0000;
        hl_seen = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #2 chk("div_t4", o1,
               pk('0, L_ZIN, S_GRB, 1'b1, A_DIV, 1'b0, 1'b0, 1'b1, 1'b0));
        #1 reset = 1'b0;
        #1 chk("div_async_rst", o1, '0);
        repeat (3) @(negedge clk);
        chk("div_no_hilo", 64'(hl_seen), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_exit_t0", o1,
            pk('0, L_PCIN | L_MARIN, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0));

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rdc = 0;
        rz  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i < 5) rdc += int'(c3.Read);
            rz = rz | c3.ld[0] | c3.ld[6];
            if (i == 0 || i == 5)
                chk($sformatf("nop_t0_%0d", i), 64'(c3.IncPC), 64'd1);
            if (i == 4)
                chk("nop_t2", 64'({c3.drv[5], c3.Read}), 64'd2);
        end
        chk("nop_read_cycles", 64'(rdc), 64'd3);
        chk("nop_no_write", 64'(rz), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
